// File: rtl/eth_fifo_pkg.sv
// Shared types for the Ethernet AXI-stream frame FIFO: write-side FSM states and stats counter width.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package eth_fifo_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_STORE = 2'd1,
        WR_DROP  = 2'd2
    } wr_state_t;

endpackage

// File: rtl/eth_fifo_ram.sv
// Simple dual-port storage with one write port, one registered read port and a single clock.
// Latency: read data is valid 1 cycle after i_rd_en and holds until the next read.
// Backpressure: none; the caller owns all flow control.
module eth_fifo_ram
    import eth_fifo_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_dat,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_dat
);

    logic [WIDTH-1:0] r_mem [0:(1<<ADDR_W)-1];

    // No reset here, so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
        if (i_rd_en) begin
            o_rd_dat <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/eth_axis_frame_fifo.sv
// Store-and-forward AXI-stream frame FIFO; ETH_FIFO_STATS_EN adds good/bad/overflow frame counters.
// Latency: m_axis_tvalid rises 2 cycles after the commit (good_frame) cycle, then 1 beat per cycle.
// Backpressure: ingress never stalls; bad or oversize frames are dropped, egress honours m_axis_tready.
module eth_axis_frame_fifo
    import eth_fifo_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
    parameter int DEPTH          = 4096,
    parameter bit DROP_BAD_FRAME = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_tready,
    output logic                  overflow,
    output logic                  bad_frame,
    output logic                  good_frame
`ifdef ETH_FIFO_STATS_EN
    ,
    output logic [CNT_W-1:0]      good_count,
    output logic [CNT_W-1:0]      bad_count,
    output logic [CNT_W-1:0]      overflow_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    typedef struct packed {
        logic                  user;
        logic                  last;
        logic [KEEP_WIDTH-1:0] keep;
        logic [DATA_WIDTH-1:0] data;
    } word_t;

    wr_state_t       r_wr_state;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_wr_commit;
    logic [PW-1:0]   r_rd_ptr;
    logic            r_good_frame;
    logic            r_bad_frame;
    logic            r_overflow;
    logic            r_ram_vld;
    logic            r_out_vld;
    word_t           r_out;

    logic            w_accept;
    logic            w_full;
    logic            w_empty;
    logic            w_wr_en;
    logic            w_bad_last;
    logic [PW-1:0]   w_wr_ptr_nxt;
    logic            w_rd_en;
    logic            w_out_ld;
    word_t           w_wr_word;
    word_t           w_rd_word;

    // Ingress is never throttled; it is only closed while reset is held.
    assign s_axis_tready = rst_n;
    assign w_accept      = s_axis_tvalid & s_axis_tready;

    // r_rd_ptr is a register, so a read in this cycle cannot make room for this cycle's write.
    assign w_full       = (r_wr_ptr - r_rd_ptr) == DEPTH_P;
    assign w_empty      = (r_wr_commit == r_rd_ptr);
    assign w_wr_en      = w_accept & (r_wr_state != WR_DROP) & ~w_full;
    assign w_bad_last   = DROP_BAD_FRAME & s_axis_tuser;
    assign w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;

    // tuser is only meaningful on the tlast beat, so it is stored there alone.
    assign w_wr_word.user = s_axis_tuser & s_axis_tlast;
    assign w_wr_word.last = s_axis_tlast;
    assign w_wr_word.keep = s_axis_tkeep;
    assign w_wr_word.data = s_axis_tdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_state   <= WR_IDLE;
            r_wr_ptr     <= '0;
            r_wr_commit  <= '0;
            r_good_frame <= 1'b0;
            r_bad_frame  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_good_frame <= 1'b0;
            r_bad_frame  <= 1'b0;
            r_overflow   <= 1'b0;
            if (w_accept) begin
                if (w_wr_en) begin
                    if (s_axis_tlast) begin
                        r_wr_state <= WR_IDLE;
                        if (w_bad_last) begin
                            r_wr_ptr    <= r_wr_commit;
                            r_bad_frame <= 1'b1;
                        end else begin
                            r_wr_ptr     <= w_wr_ptr_nxt;
                            r_wr_commit  <= w_wr_ptr_nxt;
                            r_good_frame <= 1'b1;
                        end
                    end else begin
                        r_wr_ptr   <= w_wr_ptr_nxt;
                        r_wr_state <= WR_STORE;
                    end
                end else begin
                    // Full, or already dropping: rewind and swallow beats until tlast.
                    r_wr_ptr <= r_wr_commit;
                    if (s_axis_tlast) begin
                        r_wr_state <= WR_IDLE;
                        r_overflow <= 1'b1;
                    end else begin
                        r_wr_state <= WR_DROP;
                    end
                end
            end
        end
    end

    eth_fifo_ram #(
        .WIDTH  ($bits(word_t)),
        .ADDR_W (AW)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr[AW-1:0]),
        .i_wr_dat  (w_wr_word),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_dat  (w_rd_word)
    );

    // Two-stage read pipe (RAM output, then output register); each stage advances only when the next can take it.
    assign w_out_ld = r_ram_vld & (~r_out_vld | m_axis_tready);
    assign w_rd_en  = ~w_empty & (~r_ram_vld | w_out_ld);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr  <= '0;
            r_ram_vld <= 1'b0;
            r_out_vld <= 1'b0;
            r_out     <= '0;
        end else begin
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_ram_vld <= w_rd_en | (r_ram_vld & ~w_out_ld);
            if (w_out_ld) begin
                r_out_vld <= 1'b1;
                r_out     <= w_rd_word;
            end else if (m_axis_tready) begin
                r_out_vld <= 1'b0;
            end
        end
    end

    assign m_axis_tvalid = r_out_vld;
    assign m_axis_tdata  = r_out.data;
    assign m_axis_tkeep  = r_out.keep;
    assign m_axis_tlast  = r_out.last;
    assign m_axis_tuser  = r_out.user;

    assign good_frame = r_good_frame;
    assign bad_frame  = r_bad_frame;
    assign overflow   = r_overflow;

`ifdef ETH_FIFO_STATS_EN
    logic [CNT_W-1:0] r_good_cnt;
    logic [CNT_W-1:0] r_bad_cnt;
    logic [CNT_W-1:0] r_ovf_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
            r_ovf_cnt  <= '0;
        end else begin
            if (r_good_frame) begin
                r_good_cnt <= r_good_cnt + CNT_W'(1);
            end
            if (r_bad_frame) begin
                r_bad_cnt <= r_bad_cnt + CNT_W'(1);
            end
            if (r_overflow) begin
                r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
            end
        end
    end

    assign good_count     = r_good_cnt;
    assign bad_count      = r_bad_cnt;
    assign overflow_count = r_ovf_cnt;
`endif

endmodule
